// File: rtl/frame_pixel_feeder.sv
// Pixel ingress for the integral-image row chain: accepts a framed pixel stream,
// tracks column/row, and presents each accepted pixel to the row chain one cycle later.
module frame_pixel_feeder #(
    parameter int DATA_WIDTH_8   = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int FRAME_WIDTH    = 320,
    parameter int FRAME_HEIGHT   = 240,
    parameter int INTEGRAL_WIDTH = 3
) (
    input  logic                    clk_os,
    input  logic                    reset_os,
    input  logic                    i_pixel_valid,
    input  logic [DATA_WIDTH_8-1:0] i_pixel,
    input  logic                    i_sof,
    input  logic                    i_hold,
    output logic                    o_pixel_ready,
    output logic                    o_wen,
    output logic [DATA_WIDTH_8-1:0] o_fifo_in,
    output logic [ADDR_WIDTH-1:0]   o_col,
    output logic [ADDR_WIDTH-1:0]   o_row,
    output logic                    o_window_valid,
    output logic                    o_row_end,
    output logic                    o_frame_end,
    output logic                    o_error
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_END} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_MIN  = ADDR_WIDTH'(INTEGRAL_WIDTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   col, row, col_nxt, row_nxt;
    logic [ADDR_WIDTH-1:0]   wr_col, wr_row;
    logic                    accept, write_en, err_nxt, fend_nxt;

    assign o_pixel_ready = !reset_os && !i_hold && (state != S_END);

    // A start-of-frame pixel always lands at (0,0); mid-frame it also flags an error.
    always_comb begin
        accept    = i_pixel_valid & o_pixel_ready;
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        wr_col    = col;
        wr_row    = row;
        write_en  = 1'b0;
        err_nxt   = 1'b0;
        fend_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept && i_sof) begin
                    write_en = 1'b1;
                    wr_col   = '0;
                    wr_row   = '0;
                end
            end
            S_FILL, S_RUN: begin
                if (accept) begin
                    write_en = 1'b1;
                    if (i_sof) begin
                        err_nxt = 1'b1;
                        wr_col  = '0;
                        wr_row  = '0;
                    end
                end
            end
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (write_en) begin
            if (wr_col == LAST_COL) begin
                col_nxt = '0;
                if (wr_row == LAST_ROW) begin
                    row_nxt   = '0;
                    state_nxt = S_END;
                    fend_nxt  = 1'b1;
                end else begin
                    row_nxt   = wr_row + 1'b1;
                    state_nxt = (row_nxt >= WIN_MIN) ? S_RUN : S_FILL;
                end
            end else begin
                col_nxt   = wr_col + 1'b1;
                row_nxt   = wr_row;
                state_nxt = (wr_row >= WIN_MIN) ? S_RUN : S_FILL;
            end
        end
    end

    // Data-path outputs only update on a write so they hold their last value.
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state          <= S_IDLE;
            col            <= '0;
            row            <= '0;
            o_wen          <= 1'b0;
            o_fifo_in      <= '0;
            o_col          <= '0;
            o_row          <= '0;
            o_window_valid <= 1'b0;
            o_row_end      <= 1'b0;
            o_frame_end    <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            o_wen       <= write_en;
            o_frame_end <= fend_nxt;
            o_error     <= err_nxt;
            if (write_en) begin
                o_fifo_in      <= i_pixel;
                o_col          <= wr_col;
                o_row          <= wr_row;
                o_window_valid <= (wr_row >= WIN_MIN) && (wr_col >= WIN_MIN);
                o_row_end      <= (wr_col == LAST_COL);
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_feeder.sv
// Bench for frame_pixel_feeder: directed scenarios plus random traffic, checked
// against a linear pixel-index model of the frame.
module tb_frame_pixel_feeder;

    localparam int FW = 4;
    localparam int FH = 3;
    localparam int IW = 2;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk_os = 1'b0;
    logic          reset_os;
    logic          i_pixel_valid;
    logic [DW-1:0] i_pixel;
    logic          i_sof;
    logic          i_hold;
    logic          o_pixel_ready;
    logic          o_wen;
    logic [DW-1:0] o_fifo_in;
    logic [AW-1:0] o_col;
    logic [AW-1:0] o_row;
    logic          o_window_valid;
    logic          o_row_end;
    logic          o_frame_end;
    logic          o_error;

    always #5 clk_os = ~clk_os;

    frame_pixel_feeder #(
        .DATA_WIDTH_8  (DW),
        .ADDR_WIDTH    (AW),
        .FRAME_WIDTH   (FW),
        .FRAME_HEIGHT  (FH),
        .INTEGRAL_WIDTH(IW)
    ) dut (
        .clk_os        (clk_os),
        .reset_os      (reset_os),
        .i_pixel_valid (i_pixel_valid),
        .i_pixel       (i_pixel),
        .i_sof         (i_sof),
        .i_hold        (i_hold),
        .o_pixel_ready (o_pixel_ready),
        .o_wen         (o_wen),
        .o_fifo_in     (o_fifo_in),
        .o_col         (o_col),
        .o_row         (o_row),
        .o_window_valid(o_window_valid),
        .o_row_end     (o_row_end),
        .o_frame_end   (o_frame_end),
        .o_error       (o_error)
    );

    int checks = 0;
    int errors = 0;

    bit            m_active;
    bit            m_end;
    int            m_idx;
    logic          exp_wen, exp_err, exp_fend, exp_win, exp_rend;
    logic [DW-1:0] exp_pix;
    logic [AW-1:0] exp_col, exp_row;

    bit dut_accept;
    int fend_seen, err_seen, rend_seen, win_seen, stall_seen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_end    = 0;
        m_idx    = 0;
        exp_wen  = 0;
        exp_err  = 0;
        exp_fend = 0;
        exp_win  = 0;
        exp_rend = 0;
        exp_pix  = '0;
        exp_col  = '0;
        exp_row  = '0;
    endtask

    task automatic clear_tallies();
        fend_seen  = 0;
        err_seen   = 0;
        rend_seen  = 0;
        win_seen   = 0;
        stall_seen = 0;
    endtask

    // One clock: drive inputs, check ready, advance the frame model, check all outputs.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [DW-1:0] pix,
                                 input logic sof, input logic hold);
        logic exp_ready;
        bit   acc;
        reset_os      = rst;
        i_pixel_valid = valid;
        i_pixel       = pix;
        i_sof         = sof;
        i_hold        = hold;
        #1;
        exp_ready = !rst && !hold && !m_end;
        checkOutput("pixel_ready", o_pixel_ready, exp_ready);
        acc        = valid && exp_ready;
        dut_accept = valid && (o_pixel_ready === 1'b1);
        @(posedge clk_os);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            exp_wen  = 0;
            exp_err  = 0;
            exp_fend = 0;
            if (m_end) begin
                m_end = 0;
            end else if (acc && (sof || m_active)) begin
                if (sof) begin
                    exp_err = m_active;
                    m_idx   = 0;
                end
                exp_wen  = 1;
                exp_pix  = pix;
                exp_col  = AW'(m_idx % FW);
                exp_row  = AW'(m_idx / FW);
                exp_win  = ((m_idx % FW) >= IW - 1) && ((m_idx / FW) >= IW - 1);
                exp_rend = ((m_idx % FW) == FW - 1);
                m_idx++;
                m_active = 1;
                if (m_idx == FW * FH) begin
                    m_active = 0;
                    m_end    = 1;
                    exp_fend = 1;
                    m_idx    = 0;
                end
            end
        end
        checkOutput("wen", o_wen, exp_wen);
        checkOutput("fifo_in", o_fifo_in, exp_pix);
        checkOutput("col", o_col, exp_col);
        checkOutput("row", o_row, exp_row);
        checkOutput("window_valid", o_window_valid, exp_win);
        checkOutput("row_end", o_row_end, exp_rend);
        checkOutput("frame_end", o_frame_end, exp_fend);
        checkOutput("error", o_error, exp_err);
        fend_seen += int'(o_frame_end === 1'b1);
        err_seen  += int'(o_error === 1'b1);
        if (o_wen === 1'b1) begin
            rend_seen += int'(o_row_end === 1'b1);
            win_seen  += int'(o_window_valid === 1'b1);
        end
    endtask

    // Holds a pixel on the bus until the feeder takes it, within a small cycle budget.
    task automatic send_pixel(input logic [DW-1:0] pix, input logic sof);
        int tries = 0;
        do begin
            applyStimulus(1'b0, 1'b1, pix, sof, 1'b0);
            tries++;
            if (!dut_accept) stall_seen++;
        end while (!dut_accept && tries < 8);
        if (!dut_accept) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout: observed no accept expected accept within 8 cycles");
        end
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        clear_tallies();

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] streaming frame");
        clear_tallies();
        for (int k = 1; k <= 12; k++) send_pixel(8'(k), k == 1);
        idle_cycle();
        idle_cycle();
        checkOutput("frame1_row_end_count", rend_seen, 3);
        checkOutput("frame1_window_count", win_seen, 6);
        checkOutput("frame1_frame_end_count", fend_seen, 1);

        $display("[TB] idle drop and backpressure");
        clear_tallies();
        send_pixel(8'hAA, 1'b0);
        send_pixel(8'hBB, 1'b0);
        checkOutput("idle_drop_no_wen", o_wen, 0);
        send_pixel(8'h01, 1'b1);
        checkOutput("after_drop_col", o_col, 0);
        for (int k = 2; k <= 6; k++) send_pixel(8'(k), 1'b0);
        for (int h = 0; h < 3; h++) applyStimulus(1'b0, 1'b1, 8'h07, 1'b0, 1'b1);
        send_pixel(8'h07, 1'b0);
        checkOutput("resume_col", o_col, 2);
        for (int k = 8; k <= 12; k++) send_pixel(8'(k), 1'b0);
        idle_cycle();
        checkOutput("bp_frame_end_count", fend_seen, 1);

        $display("[TB] mid-frame sof");
        clear_tallies();
        for (int k = 1; k <= 6; k++) send_pixel(8'(k), k == 1);
        send_pixel(8'h77, 1'b1);
        checkOutput("restart_error", o_error, 1);
        checkOutput("restart_pixel", o_fifo_in, 8'h77);
        for (int k = 1; k <= 11; k++) send_pixel(8'(8'h80 + k), 1'b0);
        idle_cycle();
        idle_cycle();
        checkOutput("restart_error_count", err_seen, 1);
        checkOutput("restart_frame_end_count", fend_seen, 1);

        $display("[TB] reset mid-frame");
        clear_tallies();
        for (int k = 1; k <= 5; k++) send_pixel(8'(k), k == 1);
        applyStimulus(1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h56, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) send_pixel(8'(8'h20 + k), k == 1);
        idle_cycle();
        checkOutput("post_reset_error_count", err_seen, 0);
        checkOutput("post_reset_frame_end_count", fend_seen, 1);

        $display("[TB] back-to-back frames");
        clear_tallies();
        for (int k = 1; k <= 24; k++) send_pixel(8'(k), (k == 1) || (k == 13));
        idle_cycle();
        idle_cycle();
        checkOutput("b2b_error_count", err_seen, 0);
        checkOutput("b2b_frame_end_count", fend_seen, 2);
        checkOutput("b2b_stall_cycles", stall_seen, 1);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(99) == 0,
                          $urandom_range(9) < 8,
                          8'($urandom),
                          $urandom_range(19) == 0,
                          $urandom_range(9) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
